// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment type, blank/off constants and the
// active-low hex decode table ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG7_BLANK = 7'h7F;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  // Every nibble has a glyph, so the decode never falls through to a default.
  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    seg7_t seg;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the application datapath (master) and the scan driver (slave):
// load strobe with display data in, display pins and status out.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  AN;
  seg7_t       SEG;
  logic        DP;
  logic        frame_start;
  logic        pending;

  modport master (
    output load, value, dp_in,
    input  AN, SEG, DP, frame_start, pending
  );

  modport slave (
    input  load, value, dp_in,
    output AN, SEG, DP, frame_start, pending
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder, shared by any
// display block that needs hex glyphs.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = seg7_decode(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Single-clock, double-buffered 8-digit multiplexed seven-segment driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] count;
  logic [2:0]       digit;
  logic [2:0]       next_digit;
  logic [31:0]      shadow_value;
  logic [7:0]       shadow_dp;
  logic [31:0]      active_value;
  logic [7:0]       active_dp;
  logic [31:0]      next_active_value;
  logic [7:0]       next_active_dp;
  logic [3:0]       next_nibble;
  seg7_t            dec_seg;
  logic             tick;
  logic             boundary;
  logic             blank;
  logic             pending_q;
  logic [7:0]       an_q;
  seg7_t            seg_q;
  logic             dp_q;
  logic             frame_start_q;

  assign tick     = (count == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (digit == 3'd7);

  // Outputs are registered from the post-edge digit and buffer contents, so a
  // load coinciding with the frame boundary is visible on that same edge.
  always_comb begin
    next_digit        = tick ? digit + 3'd1 : digit;
    next_active_value = active_value;
    next_active_dp    = active_dp;
    if (boundary) begin
      next_active_value = bus.load ? bus.value : shadow_value;
      next_active_dp    = bus.load ? bus.dp_in : shadow_dp;
    end
    next_nibble = next_active_value[{next_digit, 2'b00} +: 4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (next_nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank_mask;
  logic       upper_zero;

  // Walk down from digit 7: a digit is blank while everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = 7; i >= 1; i--) begin
      upper_zero    = upper_zero & (next_active_value[4*i +: 4] == 4'h0);
      blank_mask[i] = upper_zero & ~next_active_dp[i];
    end
  end

  assign blank = blank_mask[next_digit];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      digit         <= 3'd7;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      active_value  <= '0;
      active_dp     <= '0;
      pending_q     <= 1'b0;
      an_q          <= AN_ALL_OFF;
      seg_q         <= SEG7_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      count         <= tick ? '0 : count + CNT_W'(1);
      digit         <= next_digit;
      active_value  <= next_active_value;
      active_dp     <= next_active_dp;
      frame_start_q <= boundary;
      if (bus.load) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp_in;
      end
      if (boundary) begin
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
      if (tick) begin
        an_q  <= blank ? AN_ALL_OFF : ~(8'(1) << next_digit);
        seg_q <= blank ? SEG7_BLANK : dec_seg;
        dp_q  <= blank ? 1'b1 : ~next_active_dp[next_digit];
      end
    end
  end

  assign bus.AN          = an_q;
  assign bus.SEG         = seg_q;
  assign bus.DP          = dp_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: time-based display model checked every cycle plus
// hand-computed literal checkpoints; honours LEADING_ZERO_BLANK_EN if defined.
module tb_seg7_scan_driver;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   ne = 0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference glyphs written out from the display's segment map.
  logic [6:0] segTable [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model state: edges since reset, latest loaded data, data currently shown.
  int          mT = 0;
  logic        mValid = 1'b0;
  logic [31:0] mLatestV, mShownV;
  logic [7:0]  mLatestDp, mShownDp;
  logic        mPending;

  function automatic logic isBoundary(input int t);
    return (t % D == 0) && (t >= D) && (((t / D) - 1) % 8 == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mT        <= 0;
      mValid    <= 1'b1;
      mLatestV  <= '0;
      mLatestDp <= '0;
      mShownV   <= '0;
      mShownDp  <= '0;
      mPending  <= 1'b0;
    end else begin
      mT <= mT + 1;
      if (bus.load) begin
        mLatestV  <= bus.value;
        mLatestDp <= bus.dp_in;
      end
      if (isBoundary(mT + 1)) begin
        mShownV  <= bus.load ? bus.value : mLatestV;
        mShownDp <= bus.load ? bus.dp_in : mLatestDp;
        mPending <= 1'b0;
      end else if (bus.load) begin
        mPending <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      int          n;
      int          d;
      logic [7:0]  expAn;
      logic [6:0]  expSeg;
      logic        expDp;
      logic        expFs;
      n      = mT / D;
      expAn  = 8'hFF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
      expFs  = 1'b0;
      if (n > 0) begin
        d      = (n - 1) % 8;
        expAn  = ~(8'h01 << d);
        expSeg = segTable[(mShownV >> (4 * d)) & 32'hF];
        expDp  = ~mShownDp[d];
        expFs  = (mT % D == 0) && (d == 0);
`ifdef LEADING_ZERO_BLANK_EN
        if (d >= 1 && (mShownV >> (4 * d)) == 32'd0 && !mShownDp[d]) begin
          expAn  = 8'hFF;
          expSeg = 7'h7F;
          expDp  = 1'b1;
        end
`endif
      end
      checkOutput("model_AN", 32'(bus.AN), 32'(expAn));
      checkOutput("model_SEG", 32'(bus.SEG), 32'(expSeg));
      checkOutput("model_DP", 32'(bus.DP), 32'(expDp));
      checkOutput("model_frame_start", 32'(bus.frame_start), 32'(expFs));
      checkOutput("model_pending", 32'(bus.pending), 32'(mPending));
    end
  end

  task automatic stepTo(input int target);
    while (ne < target) begin
      @(negedge clk);
      ne++;
    end
  endtask

  // Present one load strobe, captured on the next rising edge.
  task automatic applyStimulus(input logic [31:0] v, input logic [7:0] d);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = d;
    @(negedge clk);
    ne++;
    bus.load = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_AN", 32'(bus.AN), 32'hFF);
    checkOutput("reset_SEG", 32'(bus.SEG), 32'h7F);
    checkOutput("reset_DP", 32'(bus.DP), 32'h1);
    reset = 1'b0;
    ne    = 0;

    applyStimulus(32'h1234_5678, 8'h00);
    checkOutput("load_pending", 32'(bus.pending), 32'h1);
    stepTo(4);
    checkOutput("first_AN", 32'(bus.AN), 32'hFE);
    checkOutput("first_SEG", 32'(bus.SEG), 32'h00);
    checkOutput("first_fs", 32'(bus.frame_start), 32'h1);
    checkOutput("first_pending", 32'(bus.pending), 32'h0);
    stepTo(5);
    checkOutput("fs_one_cycle", 32'(bus.frame_start), 32'h0);
    stepTo(8);
    checkOutput("d1_AN", 32'(bus.AN), 32'hFD);
    checkOutput("d1_SEG", 32'(bus.SEG), 32'h78);

    stepTo(40);
    applyStimulus(32'hFFFF_FFFF, 8'h00);
    checkOutput("mid_pending", 32'(bus.pending), 32'h1);
    checkOutput("mid_old_SEG", 32'(bus.SEG), 32'h78);
    stepTo(68);
    checkOutput("swap_SEG", 32'(bus.SEG), 32'h0E);
    checkOutput("swap_AN", 32'(bus.AN), 32'hFE);
    checkOutput("swap_pending", 32'(bus.pending), 32'h0);

    stepTo(99);
    applyStimulus(32'h0000_00A5, 8'h81);
    checkOutput("simul_SEG", 32'(bus.SEG), 32'h12);
    checkOutput("simul_DP", 32'(bus.DP), 32'h0);
    checkOutput("simul_pending", 32'(bus.pending), 32'h0);
    stepTo(101);
    checkOutput("simul_pending2", 32'(bus.pending), 32'h0);
    stepTo(112);
    checkOutput("d3_DP", 32'(bus.DP), 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("d3_AN", 32'(bus.AN), 32'hFF);
`else
    checkOutput("d3_AN", 32'(bus.AN), 32'hF7);
`endif
    stepTo(128);
    checkOutput("d7_AN", 32'(bus.AN), 32'h7F);
    checkOutput("d7_DP", 32'(bus.DP), 32'h0);
    checkOutput("d7_SEG", 32'(bus.SEG), 32'h40);

    applyStimulus(32'h0000_0042, 8'h00);
    stepTo(132);
    checkOutput("lz_d0_SEG", 32'(bus.SEG), 32'h24);
    checkOutput("lz_d0_AN", 32'(bus.AN), 32'hFE);
    stepTo(136);
    checkOutput("lz_d1_SEG", 32'(bus.SEG), 32'h19);
    checkOutput("lz_d1_AN", 32'(bus.AN), 32'hFD);
    stepTo(140);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("lz_d2_AN", 32'(bus.AN), 32'hFF);
    checkOutput("lz_d2_SEG", 32'(bus.SEG), 32'h7F);
`else
    checkOutput("lz_d2_AN", 32'(bus.AN), 32'hFB);
    checkOutput("lz_d2_SEG", 32'(bus.SEG), 32'h40);
`endif

    stepTo(141);
    applyStimulus(32'hDEAD_BEEF, 8'h00);
    checkOutput("pre_rst_pending", 32'(bus.pending), 32'h1);
    stepTo(145);
    reset = 1'b1;
    stepTo(146);
    checkOutput("rst_AN", 32'(bus.AN), 32'hFF);
    checkOutput("rst_SEG", 32'(bus.SEG), 32'h7F);
    checkOutput("rst_pending", 32'(bus.pending), 32'h0);
    reset = 1'b0;
    ne    = 0;
    stepTo(4);
    checkOutput("restart_AN", 32'(bus.AN), 32'hFE);
    checkOutput("restart_SEG", 32'(bus.SEG), 32'h40);
    checkOutput("restart_fs", 32'(bus.frame_start), 32'h1);
    stepTo(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
